// File: rtl/adder_sum_accumulator.sv
// Batch accumulator behind the 8-bit adder: sums NUM_SAMPLES {c_out, sum} results
// and offers the batch total with a sticky wrap flag over a valid/ready handshake.
module adder_sum_accumulator #(
  parameter int ACC_W       = 16,
  parameter int NUM_SAMPLES = 4,
  parameter int CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_sum,
  input  logic             in_c_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] in_count,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NUM_SAMPLES);
  localparam logic [CNT_W-1:0] ONE_COUNT  = CNT_W'(1);

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [CNT_W-1:0] count;

  logic             accept;
  logic             out_fire;
  logic [ACC_W-1:0] operand;
  logic [ACC_W:0]   acc_sum;
  logic [CNT_W-1:0] count_next;

  assign operand    = ACC_W'({in_c_out, in_sum});
  assign acc_sum    = {1'b0, acc} + {1'b0, operand};
  assign count_next = count + ONE_COUNT;

  assign in_ready = (state != HOLD) && !clear;
  assign accept   = in_valid && in_ready;
  assign out_fire = (state == HOLD) && out_ready;

  assign out_valid = (state == HOLD);
  assign out_data  = out_valid ? acc : '0;
  assign out_ovf   = out_valid ? ovf : 1'b0;
  assign in_count  = count;
  assign busy      = (state != IDLE);

  // clear outranks everything except rst, so a pending HOLD total is dropped
  // even when the consumer is ready in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      count <= '0;
    end else if (clear) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc   <= operand;
            ovf   <= 1'b0;
            count <= ONE_COUNT;
            state <= (NUM_SAMPLES == 1) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc   <= acc_sum[ACC_W-1:0];
            ovf   <= ovf | acc_sum[ACC_W];
            count <= count_next;
            if (count_next == LAST_COUNT) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_fire) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
          end
        end
        default: begin
          state <= IDLE;
          acc   <= '0;
          ovf   <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/adder_sum_accumulator.md
Name: adder_sum_accumulator

Overview:
- Downstream stage of the 8-bit adder.
- Consumes each adder result, formed as the 9-bit value {c_out, sum}, through a valid/ready handshake.
- Accumulates a batch of NUM_SAMPLES results into an ACC_W-bit register, then presents the batch total with a valid/ready output handshake and a sticky overflow flag.
- Provides batch sums for the datapath and the bench scoreboard.

Parameters:
- ACC_W, 16, accumulator and output data width; must be >= 9.
- NUM_SAMPLES, 4, number of accepted inputs per batch; must be >= 1.
- CNT_W, $clog2(NUM_SAMPLES+1), width of the sample counter and the in_count output.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous batch abort.
- in_valid  input  1  adder result present.
- in_ready  output  1  block can accept a result this cycle.
- in_sum  input  8  adder sum.
- in_c_out  input  1  adder carry out.
- out_valid  output  1  batch total present.
- out_ready  input  1  consumer accepts the total.
- out_data  output  ACC_W  batch total, modulo 2^ACC_W.
- out_ovf  output  1  at least one wrap occurred in this batch.
- in_count  output  CNT_W  samples accepted in the current batch.
- busy  output  1  state is ACCUM or HOLD.

Behaviour:
- Reset: asynchronous, active-high. All outputs and state clear immediately:
  - state=IDLE, acc=0, ovf=0, count=0.
  - out_valid=0, out_data=0, out_ovf=0, in_ready=1, busy=0.
  - Reset mid-batch discards the partial sum.
- Operand: v = {in_c_out, in_sum}, zero-extended to ACC_W, range 0..511.
- Accept: occurs when in_valid && in_ready at a rising edge.
  - in_ready = (state != HOLD) && !clear.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - On accept: acc <= v, ovf <= 0, count <= 1.
  - If NUM_SAMPLES==1, go to HOLD; otherwise go to ACCUM.
  - No accept: hold state.
- ACCUM:
  - On accept: {carry, acc} <= acc + v (ACC_W+1-bit add), with wrap-around.
  - ovf <= ovf | carry; count <= count + 1.
  - If the new count == NUM_SAMPLES, go to HOLD.
  - No accept: hold acc and count; there is no timeout.
- HOLD:
  - out_valid=1, out_data=acc, out_ovf=ovf, in_ready=0.
  - The block stalls while out_ready=0, and out_data/out_ovf stay stable.
  - On out_valid && out_ready: go to IDLE, then acc=0, count=0, ovf=0 and out_valid=0 next cycle.
  - An input is never accepted in the same cycle as the output transfer.
- Latency:
  - out_valid rises on the edge that accepts the NUM_SAMPLES-th input and is visible in the following cycle. Output is registered.
  - Minimum batch period is NUM_SAMPLES+1 cycles.
- clear (synchronous, priority below rst, above all else):
  - Next edge forces IDLE, acc=0, ovf=0, count=0, out_valid=0.
  - Any in_valid in the clear cycle is dropped (in_ready=0).
  - A pending HOLD result is discarded even if out_ready=1 in the same cycle.
- Outputs:
  - out_data and out_ovf are 0 whenever out_valid=0.
  - in_count reflects the registered count.
  - busy = (state != IDLE).
- Inputs are sampled only on accept; in_sum and in_c_out are don't-care otherwise.

Test Plan:
- Basic batch:
  - Stimulus: ACC_W=16, N=4; accept {0,0x01}, {0,0x02}, {1,0xFF}, {0,0x10} back-to-back.
  - Response: out_valid rises in the cycle after the 4th accept; out_data=0x0212 (530), out_ovf=0, in_count=4, in_ready=0.
- Backpressure:
  - Stimulus: after the batch above, hold out_ready=0 for 5 cycles with in_valid=1.
  - Response: out_valid/out_data stay stable at 0x0212, in_ready=0, no input consumed. Raising out_ready gives one transfer, then IDLE with in_ready=1 and in_count=0.
- Overflow wrap:
  - Stimulus: ACC_W=9, N=2; accept {1,0xFF} then {0,0x01}.
  - Response: out_data=0x000, out_ovf=1. The next batch of {0,0x03}, {0,0x04} gives out_data=0x007, out_ovf=0.
- Input gaps:
  - Stimulus: N=4; in_valid toggles 1,0,0,1,1,0,1 with values 5, 6, 7, 8.
  - Response: only valid cycles count; out_data=26; in_count steps 1,1,1,2,3,3,4.
- Reset mid-batch:
  - Stimulus: accept 2 samples, assert rst asynchronously between clock edges.
  - Response: outputs clear immediately (out_valid=0, in_count=0, busy=0). After release, a fresh batch of 1, 1, 1, 1 gives out_data=4.
- Clear:
  - Stimulus: clear asserted in HOLD with out_ready=1.
  - Response: no transfer, out_valid=0 next cycle, state IDLE. A clear in ACCUM with in_valid=1 drops that input and in_count=0 next cycle.
